// File: rtl/instruction_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer_if
// Description : Host/cpu-facing bundle of the instruction sequencer: program
//               load port, start/done controls and the issued-instruction
//               stream. Step controls exist only with SEQUENCER_SINGLE_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_sequencer_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  program_write_enable_in;
    logic [ADDR_WIDTH-1:0] program_write_address_in;
    logic [31:0]           program_write_data_in;
    logic                  start_in;
    logic                  tensor_core_done_in;
`ifdef SEQUENCER_SINGLE_STEP_EN
    logic                  step_mode_in;
    logic                  step_in;
`endif
    logic [31:0]           current_instruction_out;
    logic [ADDR_WIDTH-1:0] program_counter_out;
    logic                  running_out;
    logic                  halted_out;
    logic [15:0]           issued_count_out;

    modport master (
`ifdef SEQUENCER_SINGLE_STEP_EN
        output step_mode_in,
        output step_in,
`endif
        output program_write_enable_in,
        output program_write_address_in,
        output program_write_data_in,
        output start_in,
        output tensor_core_done_in,
        input  current_instruction_out,
        input  program_counter_out,
        input  running_out,
        input  halted_out,
        input  issued_count_out
    );

    modport slave (
`ifdef SEQUENCER_SINGLE_STEP_EN
        input  step_mode_in,
        input  step_in,
`endif
        input  program_write_enable_in,
        input  program_write_address_in,
        input  program_write_data_in,
        input  start_in,
        input  tensor_core_done_in,
        output current_instruction_out,
        output program_counter_out,
        output running_out,
        output halted_out,
        output issued_count_out
    );
endinterface
`default_nettype wire

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Host-loaded program memory feeding one 32-bit instruction per
//               cycle to the cpu; stalls on WAIT until tensor core done, stops
//               on HALT or end of memory. Optional single-step mode under
//               SEQUENCER_SINGLE_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
    parameter int          ADDR_WIDTH      = 4,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h00000000,
    parameter logic [7:0]  HALT_OPCODE     = 8'hFF,
    parameter logic [7:0]  WAIT_OPCODE     = 8'h08
) (
    input wire                     clock_in,
    input wire                     reset_in,
    instruction_sequencer_if.slave bus
);
    localparam int                    DEPTH       = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WAIT_TC = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic [31:0]           r_instr;
    logic [31:0]           w_next_instr;
    logic [15:0]           r_count;
    logic [15:0]           w_next_count;
    logic                  r_running;
    logic                  r_halted;
    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           w_word;
    logic                  w_write_ok;
    logic                  w_step_ok;

`ifdef SEQUENCER_SINGLE_STEP_EN
    assign w_step_ok = !bus.step_mode_in || bus.step_in;
`else
    assign w_step_ok = 1'b1;
`endif

    // Host may only modify the program while nothing is executing.
    assign w_write_ok = bus.program_write_enable_in &&
                        ((r_state == ST_IDLE) || (r_state == ST_HALTED));
    assign w_word     = r_mem[r_pc];

    // Program memory deliberately has no reset so contents survive a reset.
    always_ff @(posedge clock_in) begin
        if (w_write_ok) begin
            r_mem[bus.program_write_address_in] <= bus.program_write_data_in;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_instr = NOP_INSTRUCTION;
        w_next_count = r_count;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (bus.start_in) begin
                    w_next_state = ST_RUN;
                    w_next_pc    = '0;
                    w_next_count = '0;
                end
            end
            ST_RUN: begin
                if (w_step_ok) begin
                    if (w_word[7:0] == HALT_OPCODE) begin
                        w_next_state = ST_HALTED;
                    end else if (w_word[7:0] == WAIT_OPCODE) begin
                        w_next_state = ST_WAIT_TC;
                        w_next_pc    = r_pc + 1'b1;
                    end else begin
                        w_next_instr = w_word;
                        w_next_count = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
                        if (r_pc == c_last_addr) begin
                            w_next_state = ST_HALTED;
                        end else begin
                            w_next_pc = r_pc + 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_TC: begin
                if (bus.tensor_core_done_in) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_instr   <= NOP_INSTRUCTION;
            r_count   <= '0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pc      <= w_next_pc;
            r_instr   <= w_next_instr;
            r_count   <= w_next_count;
            r_running <= (w_next_state == ST_RUN) || (w_next_state == ST_WAIT_TC);
            r_halted  <= (w_next_state == ST_HALTED);
        end
    end

    assign bus.current_instruction_out = r_instr;
    assign bus.program_counter_out     = r_pc;
    assign bus.running_out             = r_running;
    assign bus.halted_out              = r_halted;
    assign bus.issued_count_out        = r_count;
endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_sequencer
// Description : Self-checking bench; expected issue words are queued as each
//               program is started and popped when the sequencer issues them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;
    localparam int ADDR_WIDTH = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] exp_q [$];

    instruction_sequencer_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    instruction_sequencer #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clock_in (clk),
        .reset_in (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [31:0] data);
        bus.program_write_enable_in  = 1'b1;
        bus.program_write_address_in = ADDR_WIDTH'(addr);
        bus.program_write_data_in    = data;
        tick();
        bus.program_write_enable_in  = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
    endtask

    function automatic logic [31:0] fill_word(input int i);
        return 32'h10000001 | (32'(i) << 8);
    endfunction

    // Every non-NOP word on the output is an issue and must match the queue head.
    always @(negedge clk) begin
        if (!rst && bus.current_instruction_out !== 32'h0) begin
            if (exp_q.size() == 0) check("unexpected_issue", bus.current_instruction_out, 32'h0);
            else check("issue", bus.current_instruction_out, exp_q.pop_front());
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.program_write_enable_in  = 1'b0;
        bus.program_write_address_in = '0;
        bus.program_write_data_in    = '0;
        bus.start_in                 = 1'b0;
        bus.tensor_core_done_in      = 1'b0;
`ifdef SEQUENCER_SINGLE_STEP_EN
        bus.step_mode_in = 1'b0;
        bus.step_in      = 1'b0;
`endif
        #3;
        check("rst_instr",   bus.current_instruction_out, 32'h0);
        check("rst_pc",      32'(bus.program_counter_out), 32'd0);
        check("rst_running", 32'(bus.running_out), 32'd0);
        check("rst_halted",  32'(bus.halted_out), 32'd0);
        check("rst_count",   32'(bus.issued_count_out), 32'd0);
        tick();
        rst = 1'b0;

        // Straight-line program ending in HALT
        write_word(0, 32'h01000001);
        write_word(1, 32'h02010002);
        write_word(2, 32'h000000FF);
        exp_q.push_back(32'h01000001);
        exp_q.push_back(32'h02010002);
        pulse_start();
        check("t1_running", 32'(bus.running_out), 32'd1);
        tick();
        check("t1_first", bus.current_instruction_out, 32'h01000001);
        repeat (2) tick();
        check("t1_nop",    bus.current_instruction_out, 32'h0);
        check("t1_halted", 32'(bus.halted_out), 32'd1);
        check("t1_pc",     32'(bus.program_counter_out), 32'd2);
        check("t1_count",  32'(bus.issued_count_out), 32'd2);
        check("t1_q",      32'(exp_q.size()), 32'd0);

        // WAIT stall; an early done pulse must not be remembered
        write_word(0, 32'h03050006);
        write_word(1, 32'h00000008);
        write_word(2, 32'h04000001);
        write_word(3, 32'h000000FF);
        exp_q.push_back(32'h03050006);
        exp_q.push_back(32'h04000001);
        pulse_start();
        bus.tensor_core_done_in = 1'b1;
        tick();
        bus.tensor_core_done_in = 1'b0;
        check("t2_first", bus.current_instruction_out, 32'h03050006);
        tick();
        check("t2_wait_pc", 32'(bus.program_counter_out), 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_nop", bus.current_instruction_out, 32'h0);
            check("t2_stall_run", 32'(bus.running_out), 32'd1);
        end
        bus.tensor_core_done_in = 1'b1;
        tick();
        bus.tensor_core_done_in = 1'b0;
        check("t2_resume_nop", bus.current_instruction_out, 32'h0);
        tick();
        check("t2_after_done", bus.current_instruction_out, 32'h04000001);
        tick();
        check("t2_halted", 32'(bus.halted_out), 32'd1);
        check("t2_pc",     32'(bus.program_counter_out), 32'd3);
        check("t2_count",  32'(bus.issued_count_out), 32'd2);
        check("t2_q",      32'(exp_q.size()), 32'd0);

        // Full memory without HALT: stops at last address, no wrap
        for (int i = 0; i < 16; i++) write_word(i, fill_word(i));
        for (int i = 0; i < 16; i++) exp_q.push_back(fill_word(i));
        pulse_start();
        repeat (15) tick();
        check("t3_not_yet", 32'(bus.halted_out), 32'd0);
        tick();
        check("t3_last",   bus.current_instruction_out, fill_word(15));
        check("t3_halted", 32'(bus.halted_out), 32'd1);
        tick();
        check("t3_pc",     32'(bus.program_counter_out), 32'd15);
        check("t3_count",  32'(bus.issued_count_out), 32'd16);
        check("t3_nop",    bus.current_instruction_out, 32'h0);
        check("t3_q",      32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-run, then replay
        exp_q.push_back(fill_word(0));
        exp_q.push_back(fill_word(1));
        pulse_start();
        repeat (3) tick();
        check("t4_pc3",  32'(bus.program_counter_out), 32'd3);
        check("t4_addr2", bus.current_instruction_out, fill_word(2));
        #2;
        rst = 1'b1;
        #1;
        check("t4_rst_nop", bus.current_instruction_out, 32'h0);
        check("t4_rst_pc",  32'(bus.program_counter_out), 32'd0);
        check("t4_rst_run", 32'(bus.running_out), 32'd0);
        tick();
        rst = 1'b0;
        check("t4_q", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 16; i++) exp_q.push_back(fill_word(i));
        pulse_start();
        repeat (16) tick();
        check("t4_halted", 32'(bus.halted_out), 32'd1);
        tick();
        check("t4_replay_q", 32'(exp_q.size()), 32'd0);

        // Write and start during RUN are both ignored
        for (int i = 0; i < 16; i++) exp_q.push_back(fill_word(i));
        pulse_start();
        write_word(0, 32'hAAAAAA01);
        pulse_start();
        repeat (14) tick();
        check("t5_halted", 32'(bus.halted_out), 32'd1);
        check("t5_count",  32'(bus.issued_count_out), 32'd16);
        for (int i = 0; i < 16; i++) exp_q.push_back(fill_word(i));
        pulse_start();
        tick();
        check("t5_orig_word", bus.current_instruction_out, fill_word(0));
        repeat (16) tick();
        check("t5_q", 32'(exp_q.size()), 32'd0);

`ifdef SEQUENCER_SINGLE_STEP_EN
        // Single-step: exactly one issue per step pulse
        bus.step_mode_in = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(fill_word(i));
        pulse_start();
        repeat (3) tick();
        check("t6_hold_pc", 32'(bus.program_counter_out), 32'd0);
        for (int k = 0; k < 3; k++) begin
            bus.step_in = 1'b1;
            tick();
            bus.step_in = 1'b0;
            check("t6_step", bus.current_instruction_out, fill_word(k));
            repeat (3) begin
                tick();
                check("t6_gap_nop", bus.current_instruction_out, 32'h0);
            end
        end
        check("t6_count", 32'(bus.issued_count_out), 32'd3);
        check("t6_pc",    32'(bus.program_counter_out), 32'd3);
        check("t6_q",     32'(exp_q.size()), 32'd0);
        bus.step_mode_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Upstream stage of the cpu core. It holds a small program memory loaded by the host and fetches one 32-bit instruction per cycle into the cpu's current_instruction input. It runs from address 0 on a start pulse, inserts NOPs while idle, halted or waiting on the tensor core, and stops on a HALT opcode or at end of memory.

Parameters:
ADDR_WIDTH, 4, program memory address width; DEPTH = 2**ADDR_WIDTH words.
NOP_INSTRUCTION, 32'h00000000, word driven whenever no instruction is issued.
HALT_OPCODE, 8'hFF, opcode field [7:0] that stops execution.
WAIT_OPCODE, 8'h08, opcode field [7:0] that stalls until tensor core done.

Ports:
clock_in  input  1  clock; all state updates on rising edge
reset_in  input  1  asynchronous, active-high reset
program_write_enable_in  input  1  write program_write_data_in to memory
program_write_address_in  input  ADDR_WIDTH  program memory write address
program_write_data_in  input  32  instruction word to store
start_in  input  1  begin execution at address 0
tensor_core_done_in  input  1  tensor core done pulse (from small_tensor_core)
current_instruction_out  output  32  registered instruction to cpu
program_counter_out  output  ADDR_WIDTH  address of next fetch
running_out  output  1  high in RUN or WAIT_TC
halted_out  output  1  high in HALTED
issued_count_out  output  16  count of non-NOP instructions issued since start

Behaviour:
- Reset (async, reset_in=1): state=IDLE, PC=0, current_instruction_out=NOP_INSTRUCTION, issued_count_out=0, running_out=0, halted_out=0. Program memory is not cleared. Reset mid-run aborts immediately.
- Memory: DEPTH x 32 registers, synchronous write. Writes are accepted only in IDLE or HALTED and are ignored in RUN and WAIT_TC.
- States: IDLE, RUN, WAIT_TC, HALTED.
- IDLE/HALTED: output NOP. On start_in=1, go to RUN with PC<=0 and issued_count<=0. A write in the same cycle as start is committed, and the first fetch (next cycle) sees it.
- RUN, each cycle, with word w = mem[PC]:
  - If w[7:0]==HALT_OPCODE: output NOP, go to HALTED, PC holds.
  - Else if w[7:0]==WAIT_OPCODE: output NOP, PC<=PC+1, go to WAIT_TC.
  - Else: current_instruction_out<=w and issued_count+1 (saturates at 16'hFFFF). If PC==DEPTH-1, go to HALTED with PC holding; otherwise PC<=PC+1.
  - start_in is ignored in RUN.
- WAIT_TC: output NOP. When tensor_core_done_in=1, return to RUN; the fetch occurs on the following cycle. A done pulse that arrives before WAIT_TC is entered is not remembered.
- Latency: an instruction at address k appears on current_instruction_out k+1 cycles after the start edge, absent stalls.
- Outputs: running_out = (state==RUN or WAIT_TC); halted_out = (state==HALTED). Both are registered state decodes.

Optional Feature:
SEQUENCER_SINGLE_STEP_EN:
- Defined: adds input ports step_mode_in (1) and step_in (1). While step_mode_in=1, RUN performs its fetch/issue only in a cycle where step_in=1, and outputs NOP otherwise with PC held. HALT and WAIT semantics are unchanged.
- Undefined: the ports are absent and RUN fetches every cycle.

Test Plan:
- Load addr0=32'h01000001, addr1=32'h02010002, addr2=32'h000000FF; pulse start -> outputs 01000001 then 02010002, then NOP; halted_out=1, PC=2, issued_count_out=2.
- Load addr0=32'h03050006, addr1=32'h00000008, addr2=32'h04000001; start -> 03050006, then NOP held through 5 cycles with tensor_core_done_in=0; done pulse -> 04000001 issued one cycle later.
- Fill all 16 words with opcode 01 (no HALT) -> 16 instructions issued, halted_out=1 after address 15, PC=15, no wrap to 0.
- Assert reset_in asynchronously while PC=3 in RUN -> output immediately NOP, PC=0, running_out=0; the memory contents survive and a restart replays from address 0.
- Write addr0=32'hAAAAAA01 during RUN -> mem unchanged; readback via a restart issues the original word. Start asserted in RUN -> ignored.
- With SEQUENCER_SINGLE_STEP_EN and step_mode_in=1: three step_in pulses spaced 4 cycles apart -> exactly three instructions issued, NOP between them.
